inc16: RTL and testbench
========================

Name: inc16

Overview:
- Registered 16-bit incrementer: captures an input word and presents in+1 one clock later.
- Arithmetic core is a ripple chain of half adders.
  - Carry-in of the chain is tied to 1.
  - The chain builds on the existing gate-level primitives.
- Sits in the ALU/PC datapath; used as the program-counter increment path.

Parameters:
- WIDTH, 16, data width in bits. Only 16 is required to be supported and verified.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  operand to increment.
- in_valid  input  1  operand qualifier; high means "capture in this cycle".
- out  output  WIDTH  registered result, in+1 modulo 2^WIDTH.
- out_valid  output  1  high for the cycle after a captured operand.
- carry_out  output  1  registered carry from the MSB; 1 only when in was all ones.

Behaviour:
- Reset: while rst is high, out=0, out_valid=0, carry_out=0.
  - Reset is asserted asynchronously and released synchronously to clk edges.
  - It overrides any capture in the same cycle.
- Arithmetic is combinational.
  - sum[i] = in[i] XOR c[i], c[i+1] = in[i] AND c[i], with c[0]=1.
  - carry_out = c[WIDTH].
  - No saturation: 16'hFFFF gives out=16'h0000 with carry_out=1 (wrap-around).
- Capture: on a rising clk with rst low and in_valid high:
  - out <= sum, carry_out <= c[WIDTH], out_valid <= 1.
- Hold: on a rising clk with rst low and in_valid low:
  - out and carry_out hold their previous values.
  - out_valid <= 0.
- Latency is exactly 1 cycle. Throughput is one operand per cycle; back-to-back valid operands produce back-to-back results.
- There is no backpressure: the consumer must take the result in the out_valid cycle.
- in is sampled only on the capture edge; changes between edges have no effect on the outputs.
- Reset asserted mid-stream: outputs clear immediately, with no dependence on clk; a pending result is discarded.
- carry_out is meaningful only while out_valid=1, but it holds its value like out.

Decomposition:
- Shared package: WIDTH default constant, and a reset-value constant of zero for out.
- One natural sub-module, inc16_half_adder (a, b -> sum, carry), instantiated WIDTH times in a generate chain.
  - Built from the existing xor/and primitives.
- The top level holds the chain plus the output register (out, carry_out, out_valid).

Test Plan:
- Reset: assert rst mid-cycle with out=16'h1234 and out_valid=1 -> out=16'h0000, out_valid=0 and carry_out=0 before the next clk edge; all stay 0 while rst is high.
- Simple and carry cases, one per cycle with in_valid=1:
  - 16'h0000 -> 16'h0001
  - 16'h0F01 -> 16'h0F02
  - 16'hA211 -> 16'hA212
  - 16'hA21F -> 16'hA220 (4-bit carry ripple)
  - Each result valid one cycle later, carry_out=0.
- Long ripple: 16'hEFFF -> 16'hF000, carry_out=0; 16'hFFFE -> 16'hFFFF, carry_out=0.
- Wrap: 16'hFFFF -> 16'h0000 with carry_out=1, out_valid=1 exactly one cycle later.
- Hold: after capturing 16'h0041, drop in_valid and drive in=16'hBEEF for 3 cycles -> out stays 16'h0042, out_valid=0 for all 3 cycles.
- Back-to-back: stream 16'h0000..16'h0007 on consecutive cycles -> out_valid stays high for 8 cycles with outputs 16'h0001..16'h0008 in order.

Source files
------------

// File: rtl/inc16_pkg.sv
// inc16_pkg: shared constants for the registered incrementer
package inc16_pkg;
  localparam int INC_WIDTH = 16;
  localparam logic [INC_WIDTH-1:0] OUT_RST = '0;
endpackage

// File: rtl/inc16_half_adder.sv
// inc16_half_adder: one-bit half adder from xor/and primitives
module inc16_half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  xor u_xor (sum, a, b);
  and u_and (carry, a, b);
endmodule

// File: rtl/inc16.sv
// inc16: registered incrementer, out = in + 1 one cycle after capture
module inc16
  import inc16_pkg::*;
#(
  parameter int WIDTH = INC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             carry_out
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] out_d, out_q;
  logic             carry_d, carry_q, valid_d, valid_q;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    inc16_half_adder u_ha (.a(in[i]), .b(c[i]), .sum(sum[i]), .carry(c[i+1]));
  end
  always_comb begin
    out_d   = in_valid ? sum : out_q;
    carry_d = in_valid ? c[WIDTH] : carry_q;
    valid_d = in_valid;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= OUT_RST[WIDTH-1:0];
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end
  assign out       = out_q;
  assign carry_out = carry_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_inc16.sv
// tb_inc16: directed self-checking bench for inc16
module tb_inc16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in = '0;
  logic        in_valid = 1'b0;
  logic [15:0] out;
  logic        out_valid;
  logic        carry_out;
  int          total = 0;
  int          passed = 0;

  inc16 dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
    .out(out), .out_valid(out_valid), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [15:0] eo, input logic ev, input logic ec);
    chk({tag, ".out"}, {16'h0, out}, {16'h0, eo});
    chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, ev});
    chk({tag, ".carry"}, {31'h0, carry_out}, {31'h0, ec});
  endtask

  task automatic cap(input string tag, input logic [15:0] v, input logic [15:0] eo, input logic ec);
    in = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_all(tag, eo, 1'b1, ec);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    cap("v0000", 16'h0000, 16'h0001, 1'b0);
    cap("v0F01", 16'h0F01, 16'h0F02, 1'b0);
    cap("vA211", 16'hA211, 16'hA212, 1'b0);
    cap("vA21F", 16'hA21F, 16'hA220, 1'b0);
    cap("vEFFF", 16'hEFFF, 16'hF000, 1'b0);
    cap("vFFFE", 16'hFFFE, 16'hFFFF, 1'b0);
    cap("wrap",  16'hFFFF, 16'h0000, 1'b1);
    cap("v0041", 16'h0041, 16'h0042, 1'b0);
    in_valid = 1'b0;
    in = 16'hBEEF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("hold%0d", k), 16'h0042, 1'b0, 1'b0);
    end
    for (int k = 0; k < 8; k++) cap($sformatf("b2b%0d", k), 16'(k), 16'(k + 1), 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("b2b_end", 16'h0008, 1'b0, 1'b0);
    cap("pre_rst", 16'h1233, 16'h1234, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 16'h0000, 1'b0, 1'b0);
    in = 16'h0005;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("rst_hold%0d", k), 16'h0000, 1'b0, 1'b0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst", 16'h0000, 1'b0, 1'b0);
    cap("post_rst_cap", 16'h7FFF, 16'h8000, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
